// File: rtl/dma_axi_pkg.sv
// Shared AXI4 types for the DMA slave memory.
package dma_axi_pkg;

    typedef logic [31:0] axi_addr_t;
    typedef logic [63:0] axi_data_t;
    typedef logic [7:0]  axi_strb_t;
    typedef logic [3:0]  axi_id_t;
    typedef logic [7:0]  axi_len_t;
    typedef logic [2:0]  axi_size_t;
    typedef logic [1:0]  axi_burst_t;
    typedef logic [1:0]  axi_rsp_t;

    localparam axi_burst_t AXI_BURST_INCR = 2'b01;
    localparam axi_rsp_t   AXI_RESP_OKAY  = 2'b00;
    localparam axi_rsp_t   AXI_RESP_SLVERR = 2'b10;

    typedef struct packed {
        axi_addr_t  aw_addr;
        axi_len_t   aw_len;
        axi_size_t  aw_size;
        axi_burst_t aw_burst;
        axi_id_t    aw_id;
        logic       aw_valid;
        axi_data_t  w_data;
        axi_strb_t  w_strb;
        logic       w_last;
        logic       w_valid;
        logic       b_ready;
        axi_addr_t  ar_addr;
        axi_len_t   ar_len;
        axi_size_t  ar_size;
        axi_burst_t ar_burst;
        axi_id_t    ar_id;
        logic       ar_valid;
        logic       r_ready;
    } axi_req_t;

    typedef struct packed {
        logic      aw_ready;
        logic      w_ready;
        logic      ar_ready;
        axi_rsp_t  b_resp;
        axi_id_t   b_id;
        logic      b_valid;
        axi_data_t r_data;
        axi_rsp_t  r_resp;
        logic      r_last;
        axi_id_t   r_id;
        logic      r_valid;
    } axi_resp_t;

endpackage

// File: rtl/dma_axi_slv_mem.sv
// AXI4 slave backed by a 1R1W word memory, with independent read and write burst FSMs.
module dma_axi_slv_mem
    import dma_axi_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic      clk,
    input  logic      rst,
    input  axi_req_t  axi_req_i,
    output axi_resp_t axi_resp_o,
    output logic      busy_o
);

    localparam int unsigned IDX_W      = $clog2(MEM_WORDS);
    localparam int unsigned STRB_W     = $bits(axi_strb_t);
    localparam int unsigned BYTE_SHIFT = $clog2(STRB_W);

    localparam logic       R_IDLE  = 1'b0;
    localparam logic       R_BURST = 1'b1;
    localparam logic [1:0] W_IDLE  = 2'd0;
    localparam logic [1:0] W_DATA  = 2'd1;
    localparam logic [1:0] W_RESP  = 2'd2;

    axi_data_t mem [MEM_WORDS];

    function automatic logic addr_ok(input axi_addr_t addr);
        axi_addr_t word;
        word = (addr - BASE_ADDR) >> BYTE_SHIFT;
        return (addr >= BASE_ADDR) && (word < axi_addr_t'(MEM_WORDS));
    endfunction

    // Only meaningful when addr_ok() holds; MEM_WORDS is a power of two so truncation is safe.
    function automatic logic [IDX_W-1:0] addr_idx(input axi_addr_t addr);
        return IDX_W'((addr - BASE_ADDR) >> BYTE_SHIFT);
    endfunction

    // Read channel state
    logic       r_state_q;
    axi_addr_t  r_addr_q;
    axi_len_t   r_len_q;
    axi_len_t   r_cnt_q;
    axi_size_t  r_size_q;
    axi_burst_t r_burst_q;
    axi_id_t    r_id_q;
    axi_data_t  r_data_q;
    axi_rsp_t   r_resp_q;
    logic       r_last_q;

    // Write channel state
    logic [1:0] w_state_q;
    axi_addr_t  w_addr_q;
    axi_len_t   w_len_q;
    axi_len_t   w_cnt_q;
    axi_size_t  w_size_q;
    axi_burst_t w_burst_q;
    axi_id_t    w_id_q;
    logic       w_err_q;

    logic ar_ready, r_valid, ar_fire, r_fire;
    logic aw_ready, w_ready, b_valid, aw_fire, w_fire, b_fire;

    assign ar_ready = rst && (r_state_q == R_IDLE);
    assign r_valid  = rst && (r_state_q == R_BURST);
    assign aw_ready = rst && (w_state_q == W_IDLE);
    assign w_ready  = rst && (w_state_q == W_DATA);
    assign b_valid  = rst && (w_state_q == W_RESP);
    assign ar_fire  = axi_req_i.ar_valid && ar_ready;
    assign r_fire   = r_valid && axi_req_i.r_ready;
    assign aw_fire  = axi_req_i.aw_valid && aw_ready;
    assign w_fire   = axi_req_i.w_valid && w_ready;
    assign b_fire   = b_valid && axi_req_i.b_ready;
    assign busy_o   = rst && ((r_state_q != R_IDLE) || (w_state_q != W_IDLE));

    // Address and data of the next read beat to be registered into the R channel
    axi_addr_t rd_addr;
    logic      rd_ok;
    axi_data_t rd_data;
    always_comb begin
        rd_addr = ar_fire ? axi_req_i.ar_addr : r_addr_q + (axi_addr_t'(1) << r_size_q);
        rd_ok   = addr_ok(rd_addr) &&
                  ((ar_fire ? axi_req_i.ar_burst : r_burst_q) == AXI_BURST_INCR);
        rd_data = rd_ok ? mem[addr_idx(rd_addr)] : '0;
    end

    // Read FSM: accept AR, then present registered beats until the last one is taken
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state_q <= R_IDLE;
            r_cnt_q   <= '0;
            r_data_q  <= '0;
            r_resp_q  <= AXI_RESP_OKAY;
            r_last_q  <= 1'b0;
        end else begin
            case (r_state_q)
                R_IDLE: begin
                    if (ar_fire) begin
                        r_addr_q  <= rd_addr;
                        r_len_q   <= axi_req_i.ar_len;
                        r_size_q  <= axi_req_i.ar_size;
                        r_burst_q <= axi_req_i.ar_burst;
                        r_id_q    <= axi_req_i.ar_id;
                        r_cnt_q   <= '0;
                        r_data_q  <= rd_data;
                        r_resp_q  <= rd_ok ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
                        r_last_q  <= (axi_req_i.ar_len == '0);
                        r_state_q <= R_BURST;
                    end
                end
                R_BURST: begin
                    if (r_fire) begin
                        if (r_last_q) begin
                            r_last_q  <= 1'b0;
                            r_state_q <= R_IDLE;
                        end else begin
                            r_addr_q <= rd_addr;
                            r_cnt_q  <= r_cnt_q + 8'd1;
                            r_data_q <= rd_data;
                            r_resp_q <= rd_ok ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
                            r_last_q <= ((r_cnt_q + 8'd1) == r_len_q);
                        end
                    end
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

    logic             wr_ok;
    logic             wr_last_beat;
    logic [IDX_W-1:0] wr_idx;
    assign wr_ok        = addr_ok(w_addr_q) && (w_burst_q == AXI_BURST_INCR);
    assign wr_last_beat = (w_cnt_q == w_len_q);
    assign wr_idx       = addr_idx(w_addr_q);

    // Byte-enabled memory write; storage is deliberately not reset
    always_ff @(posedge clk) begin
        if (w_fire && wr_ok) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (axi_req_i.w_strb[b]) begin
                    mem[wr_idx][8*b +: 8] <= axi_req_i.w_data[8*b +: 8];
                end
            end
        end
    end

    // Write FSM: accept AW, count beats to awlen (wlast only checked), then hold B
    always_ff @(posedge clk) begin
        if (!rst) begin
            w_state_q <= W_IDLE;
            w_cnt_q   <= '0;
            w_err_q   <= 1'b0;
        end else begin
            case (w_state_q)
                W_IDLE: begin
                    if (aw_fire) begin
                        w_addr_q  <= axi_req_i.aw_addr;
                        w_len_q   <= axi_req_i.aw_len;
                        w_size_q  <= axi_req_i.aw_size;
                        w_burst_q <= axi_req_i.aw_burst;
                        w_id_q    <= axi_req_i.aw_id;
                        w_cnt_q   <= '0;
                        w_err_q   <= 1'b0;
                        w_state_q <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_fire) begin
                        w_err_q <= w_err_q || !wr_ok || (axi_req_i.w_last != wr_last_beat);
                        if (wr_last_beat) begin
                            w_state_q <= W_RESP;
                        end else begin
                            w_addr_q <= w_addr_q + (axi_addr_t'(1) << w_size_q);
                            w_cnt_q  <= w_cnt_q + 8'd1;
                        end
                    end
                end
                W_RESP: begin
                    if (b_fire) begin
                        w_state_q <= W_IDLE;
                    end
                end
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    // Response bundle: payloads are zero whenever their valid is low
    always_comb begin
        axi_resp_o          = '0;
        axi_resp_o.aw_ready = aw_ready;
        axi_resp_o.w_ready  = w_ready;
        axi_resp_o.ar_ready = ar_ready;
        axi_resp_o.b_valid  = b_valid;
        axi_resp_o.r_valid  = r_valid;
        if (b_valid) begin
            axi_resp_o.b_resp = w_err_q ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
            axi_resp_o.b_id   = w_id_q;
        end
        if (r_valid) begin
            axi_resp_o.r_data = r_data_q;
            axi_resp_o.r_resp = r_resp_q;
            axi_resp_o.r_last = r_last_q;
            axi_resp_o.r_id   = r_id_q;
        end
    end

endmodule

// File: tb/tb_dma_axi_slv_mem.sv
// Directed bench for dma_axi_slv_mem with a byte-level memory model and R/B scoreboards.
module tb_dma_axi_slv_mem;
    import dma_axi_pkg::*;

    localparam int unsigned MEM_WORDS = 16;
    localparam logic [31:0] BASE      = 32'h0000_1000;

    logic      clk = 1'b0;
    logic      rst = 1'b0;
    axi_req_t  req;
    axi_resp_t resp;
    logic      busy;

    always #5 clk = ~clk;

    dma_axi_slv_mem #(
        .MEM_WORDS(MEM_WORDS),
        .BASE_ADDR(BASE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .axi_req_i (req),
        .axi_resp_o(resp),
        .busy_o    (busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Byte-addressed model of the memory window
    logic [7:0] model_mem [MEM_WORDS*8];

    function automatic bit beat_ok(input logic [31:0] addr, input logic [1:0] burst);
        return (burst == 2'b01) && (addr >= BASE) && ((addr - BASE) / 8 < MEM_WORDS);
    endfunction

    function automatic logic [63:0] model_word(input logic [31:0] addr);
        int base_byte;
        logic [63:0] w;
        base_byte = int'((addr - BASE) / 8) * 8;
        for (int b = 0; b < 8; b++) w[8*b +: 8] = model_mem[base_byte + b];
        return w;
    endfunction

    typedef struct {
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [3:0]  id;
    } rbeat_t;
    typedef struct {
        logic [1:0] resp;
        logic [3:0] id;
    } bresp_t;

    rbeat_t      r_exp[$];
    bresp_t      b_exp[$];
    logic [63:0] cap_data[$];
    logic [1:0]  cap_resp[$];
    logic        cap_last[$];
    logic [1:0]  last_bresp;
    int          r_pops = 0;
    int          b_pops = 0;

    // Scoreboard: every cycle a response valid is up, it must match the model's head entry
    always @(negedge clk) begin
        if (resp.r_valid) begin
            if (r_exp.size() == 0) begin
                check("unexpected_rvalid", 64'(resp.r_valid), 64'd0);
            end else begin
                check("rdata", resp.r_data, r_exp[0].data);
                check("rresp", 64'(resp.r_resp), 64'(r_exp[0].resp));
                check("rlast", 64'(resp.r_last), 64'(r_exp[0].last));
                check("rid", 64'(resp.r_id), 64'(r_exp[0].id));
                if (req.r_ready) begin
                    cap_data.push_back(resp.r_data);
                    cap_resp.push_back(resp.r_resp);
                    cap_last.push_back(resp.r_last);
                    void'(r_exp.pop_front());
                    r_pops++;
                end
            end
        end
        if (resp.b_valid) begin
            if (b_exp.size() == 0) begin
                check("unexpected_bvalid", 64'(resp.b_valid), 64'd0);
            end else begin
                check("bresp", 64'(resp.b_resp), 64'(b_exp[0].resp));
                check("bid", 64'(resp.b_id), 64'(b_exp[0].id));
                if (req.b_ready) begin
                    last_bresp = resp.b_resp;
                    void'(b_exp.pop_front());
                    b_pops++;
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for a ready, then step past the edge that completes the handshake
    task automatic hs(input int which, input string name);
        logic rdy;
        int   t;
        t = 0;
        forever begin
            @(negedge clk);
            case (which)
                0:       rdy = resp.aw_ready;
                1:       rdy = resp.w_ready;
                default: rdy = resp.ar_ready;
            endcase
            if (rdy || t >= 100) break;
            t++;
        end
        check(name, 64'(rdy), 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                            input logic [3:0] id, input logic [63:0] data0, input logic [7:0] strb,
                            input int wlast_beat, input int abort_at);
        logic [31:0] a;
        logic [63:0] d;
        logic [1:0]  exp_resp;
        int          t;
        int          target;
        exp_resp = 2'b00;
        req.aw_addr  = addr;
        req.aw_len   = len;
        req.aw_size  = 3'd3;
        req.aw_burst = burst;
        req.aw_id    = id;
        req.aw_valid = 1'b1;
        hs(0, "awready");
        req.aw_valid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            a = addr + 32'(i * 8);
            d = data0 + 64'(i);
            req.w_valid = 1'b1;
            req.w_data  = d;
            req.w_strb  = strb;
            req.w_last  = (i == wlast_beat);
            if (i == abort_at) begin
                rst = 1'b0;
                cyc(1);
                check("rst_awready", 64'(resp.aw_ready), 64'd0);
                check("rst_arready", 64'(resp.ar_ready), 64'd0);
                check("rst_wready", 64'(resp.w_ready), 64'd0);
                check("rst_busy", 64'(busy), 64'd0);
                cyc(2);
                rst = 1'b1;
                req.w_valid = 1'b0;
                req.w_last  = 1'b0;
                @(posedge clk);
                @(negedge clk);
                check("post_rst_awready", 64'(resp.aw_ready), 64'd1);
                check("post_rst_arready", 64'(resp.ar_ready), 64'd1);
                check("post_rst_busy", 64'(busy), 64'd0);
                return;
            end
            hs(1, "wready");
            if (beat_ok(a, burst)) begin
                for (int b = 0; b < 8; b++) begin
                    if (strb[b]) model_mem[int'((a - BASE) / 8) * 8 + b] = d[8*b +: 8];
                end
            end else begin
                exp_resp = 2'b10;
            end
            if ((i == wlast_beat) != (i == int'(len))) exp_resp = 2'b10;
        end
        req.w_valid = 1'b0;
        req.w_last  = 1'b0;
        b_exp.push_back('{resp: exp_resp, id: id});
        target = b_pops + 1;
        req.b_ready = 1'b1;
        t = 0;
        while (b_pops < target && t < 100) begin
            cyc(1);
            t++;
        end
        check("b_handshake", 64'(b_pops >= target), 64'd1);
        req.b_ready = 1'b0;
        b_exp.delete();
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                           input logic [3:0] id, input int stall_beat, input int stall_n);
        logic [31:0] a;
        bit          ok;
        bit          stalled;
        int          start;
        int          t;
        cap_data.delete();
        cap_resp.delete();
        cap_last.delete();
        for (int i = 0; i <= int'(len); i++) begin
            a  = addr + 32'(i * 8);
            ok = beat_ok(a, burst);
            r_exp.push_back('{data: ok ? model_word(a) : 64'd0, resp: ok ? 2'b00 : 2'b10,
                              last: (i == int'(len)), id: id});
        end
        start = r_pops;
        req.ar_addr  = addr;
        req.ar_len   = len;
        req.ar_size  = 3'd3;
        req.ar_burst = burst;
        req.ar_id    = id;
        req.ar_valid = 1'b1;
        hs(2, "arready");
        req.ar_valid = 1'b0;
        check("busy_in_read", 64'(busy), 64'd1);
        req.r_ready = 1'b1;
        stalled = 1'b0;
        t = 0;
        while (r_pops < start + int'(len) + 1 && t < 200) begin
            if (stall_beat >= 0 && !stalled && r_pops == start + stall_beat) begin
                req.r_ready = 1'b0;
                cyc(stall_n);
                req.r_ready = 1'b1;
                stalled = 1'b1;
            end else begin
                cyc(1);
            end
            t++;
        end
        check("r_burst_done", 64'(r_pops), 64'(start + int'(len) + 1));
        check("arready_after_last", 64'(resp.ar_ready), 64'd1);
        req.r_ready = 1'b0;
        r_exp.delete();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        req = '0;
        rst = 1'b0;
        cyc(3);
        check("reset_awready", 64'(resp.aw_ready), 64'd0);
        check("reset_arready", 64'(resp.ar_ready), 64'd0);
        check("reset_wready", 64'(resp.w_ready), 64'd0);
        check("reset_bvalid", 64'(resp.b_valid), 64'd0);
        check("reset_rvalid", 64'(resp.r_valid), 64'd0);
        check("reset_rlast", 64'(resp.r_last), 64'd0);
        check("reset_rdata", resp.r_data, 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        rst = 1'b1;
        #1;
        check("first_awready", 64'(resp.aw_ready), 64'd1);
        check("first_arready", 64'(resp.ar_ready), 64'd1);

        // Fill the whole window: word i = 0123_4567_0000_000i
        do_write(BASE, 8'd15, 2'b01, 4'd1, 64'h0123_4567_0000_0000, 8'hFF, 15, -1);

        // 4-beat write at BASE+0x10 then read back
        do_write(BASE + 32'h10, 8'd3, 2'b01, 4'd2, 64'hA0, 8'hFF, 3, -1);
        check("wr4_bresp", 64'(last_bresp), 64'd0);
        do_read(BASE + 32'h10, 8'd3, 2'b01, 4'd3, -1, 0);
        check("rd4_beat0", cap_data[0], 64'hA0);
        check("rd4_beat3", cap_data[3], 64'hA3);
        check("rd4_last2", 64'(cap_last[2]), 64'd0);
        check("rd4_last3", 64'(cap_last[3]), 64'd1);

        // 8-beat read with rready low for 5 cycles on beat 1
        do_read(BASE, 8'd7, 2'b01, 4'd4, 1, 5);
        check("stall_beat1", cap_data[1], 64'h0123_4567_0000_0001);
        check("stall_beat7", cap_data[7], 64'h0123_4567_0000_0007);
        check("idle_busy", 64'(busy), 64'd0);

        // Partial strobe over an all-ones word
        do_write(BASE + 32'h30, 8'd0, 2'b01, 4'd5, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, -1);
        do_write(BASE + 32'h30, 8'd0, 2'b01, 4'd5, 64'h0, 8'h0F, 0, -1);
        do_read(BASE + 32'h30, 8'd0, 2'b01, 4'd6, -1, 0);
        check("strb_word", cap_data[0], 64'hFFFF_FFFF_0000_0000);

        // Read straddling the top of the window
        do_read(BASE + 32'h78, 8'd1, 2'b01, 4'd7, -1, 0);
        check("top_beat0_resp", 64'(cap_resp[0]), 64'd0);
        check("top_beat0_data", cap_data[0], 64'h0123_4567_0000_000F);
        check("top_beat1_resp", 64'(cap_resp[1]), 64'd2);
        check("top_beat1_data", cap_data[1], 64'd0);

        // Early wlast on beat 1 of a 4-beat burst
        do_write(BASE + 32'h40, 8'd3, 2'b01, 4'd8, 64'h5000, 8'hFF, 1, -1);
        check("early_wlast_bresp", 64'(last_bresp), 64'd2);

        // Non-INCR bursts and below-window accesses
        do_write(BASE + 32'h60, 8'd0, 2'b00, 4'd9, 64'hBAD, 8'hFF, 0, -1);
        check("fixed_wr_bresp", 64'(last_bresp), 64'd2);
        do_read(BASE + 32'h60, 8'd0, 2'b01, 4'd9, -1, 0);
        check("fixed_wr_nowrite", cap_data[0], 64'h0123_4567_0000_000C);
        do_read(BASE + 32'h60, 8'd1, 2'b10, 4'd10, -1, 0);
        check("wrap_rd_resp", 64'(cap_resp[1]), 64'd2);
        do_write(BASE - 32'h8, 8'd0, 2'b01, 4'd11, 64'h77, 8'hFF, 0, -1);
        check("below_wr_bresp", 64'(last_bresp), 64'd2);
        do_read(BASE - 32'h8, 8'd0, 2'b01, 4'd11, -1, 0);

        // Reset during beat 2 of an 8-beat write; B must never appear
        do_write(BASE, 8'd7, 2'b01, 4'd12, 64'hDEAD_0000_0000_0000, 8'hFF, 7, 2);
        cyc(10);
        do_read(BASE, 8'd3, 2'b01, 4'd13, -1, 0);
        check("abort_word1", cap_data[1], 64'hDEAD_0000_0000_0001);
        check("abort_word2", cap_data[2], 64'hA0);
        check("abort_word3", cap_data[3], 64'hA1);

        cyc(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
